// File: rtl/codix_risc_ca_issue_pkg.sv
// -----------------------------------------------------------------------------
// codix_risc_ca_issue_pkg
//
// Shared definitions for the instruction issue stage that feeds the
// codix_risc_ca core instruction decoder (ACT / id_instr_Q0 interface).
//
// Contents:
//   INSTR_W       instruction word width seen by the decoder
//   NOP_INSTR     word presented on id_instr_Q0 while ACT is low
//   DEFAULT_DEPTH default number of FIFO entries (power of two, >= 2)
//   instr_t       instruction word type
//   slot_op_e     what the output slot does on the coming clock edge
//   cnt_w()       width of an occupancy counter able to hold 0..depth
// -----------------------------------------------------------------------------
package codix_risc_ca_issue_pkg;

   localparam int INSTR_W       = 12;
   localparam int DEFAULT_DEPTH = 4;

   typedef logic [INSTR_W-1:0] instr_t;

   localparam instr_t NOP_INSTR = 12'h000;

   // Decision taken for the output register on the next edge. Kept as an
   // explicit, named signal in the top level so it can be probed directly.
   typedef enum logic [2:0] {
      SLOT_IDLE        = 3'd0,  // nothing to present: ACT low, NOP driven
      SLOT_FLUSH       = 3'd1,  // pipeline flush: slot and FIFO discarded
      SLOT_HOLD        = 3'd2,  // decoder stalled on a valid instruction
      SLOT_LOAD_FIFO   = 3'd3,  // load the FIFO head, pop it
      SLOT_LOAD_BYPASS = 3'd4   // load the incoming fetch word directly
   } slot_op_e;

   // Occupancy counters must represent the full value "depth", hence +1.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/codix_risc_ca_issue_fifo.sv
// -----------------------------------------------------------------------------
// codix_risc_ca_issue_fifo
//
// Small synchronous FIFO buffering fetched instruction words ahead of the
// decoder output register. Head is combinational from the read pointer so
// the output register can load it on the same edge that pops it.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (pointers and count to 0)
//   clr    in   synchronous clear, same effect as rst; a same-cycle push
//               is dropped
//   push   in   write din at the write pointer (ignored when full)
//   pop    in   advance the read pointer (ignored when empty)
//   din    in   word to write
//   head   out  word at the read pointer
//   count  out  number of stored words, 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
//
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module codix_risc_ca_issue_fifo
   import codix_risc_ca_issue_pkg::*;
#(
   parameter int W     = INSTR_W,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      push,
   input  logic                      pop,
   input  logic [W-1:0]              din,
   output logic [W-1:0]              head,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      full,
   output logic                      empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         // Simultaneous push and pop leave the occupancy unchanged.
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !rst && !clr) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/codix_risc_ca_id_instr_issue.sv
// -----------------------------------------------------------------------------
// codix_risc_ca_id_instr_issue
//
// Producer side of the codix_risc_ca decoder input interface. Fetched words
// are buffered in a small FIFO and presented one per cycle through a
// registered output stage (ACT / id_instr_Q0), honouring stall and flush.
//
// Ports:
//   CLK          in   core clock
//   RST          in   synchronous active-high reset
//   fetch_valid  in   fetch presents a word
//   fetch_instr  in   fetched instruction word
//   fetch_ready  out  FIFO can accept a word
//   stall        in   decoder holds the current instruction
//   flush        in   discard all buffered and presented instructions
//   ACT          out  id_instr_Q0 holds a valid instruction this cycle
//   id_instr_Q0  out  instruction presented to the decoder (NOP_INSTR
//                     whenever ACT is low)
//   fifo_cnt     out  FIFO occupancy, excluding the output register
//
// Fetch handshake: a word transfers on a rising CLK edge where fetch_valid
// and fetch_ready are both high and flush is low. fetch_ready depends only
// on the registered occupancy (fifo_cnt < DEPTH), never on a same-cycle pop,
// so it carries no combinational path from stall/flush or the decoder side.
//
// Build option: define CODIX_RISC_CA_ISSUE_BYPASS_EN to let a word arriving
// while the FIFO is empty load the output register directly on its accept
// edge (one cycle latency). Without it every word passes through the FIFO
// (two cycle latency).
// -----------------------------------------------------------------------------
module codix_risc_ca_id_instr_issue
   import codix_risc_ca_issue_pkg::*;
#(
   parameter int                 INSTR_W   = codix_risc_ca_issue_pkg::INSTR_W,
   parameter int                 DEPTH     = DEFAULT_DEPTH,
   parameter logic [INSTR_W-1:0] NOP_INSTR = codix_risc_ca_issue_pkg::NOP_INSTR
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      fetch_valid,
   input  logic [INSTR_W-1:0]        fetch_instr,
   output logic                      fetch_ready,
   input  logic                      stall,
   input  logic                      flush,
   output logic                      ACT,
   output logic [INSTR_W-1:0]        id_instr_Q0,
   output logic [cnt_w(DEPTH)-1:0]   fifo_cnt
);

   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   logic [INSTR_W-1:0] fifo_head;
   logic               push_req;

   slot_op_e           slot_op;
   logic               act_q;
   logic [INSTR_W-1:0] instr_q;
   logic               act_d;
   logic [INSTR_W-1:0] instr_d;

   assign fetch_ready = !fifo_full;
   assign push_req    = fetch_valid && fetch_ready && !flush;

   // Output slot decision, highest priority first. A stall only matters when
   // the slot holds something; an empty slot keeps filling under stall.
   always_comb begin
      slot_op = SLOT_IDLE;
      if (flush) begin
         slot_op = SLOT_FLUSH;
      end else if (stall && act_q) begin
         slot_op = SLOT_HOLD;
      end else if (!fifo_empty) begin
         slot_op = SLOT_LOAD_FIFO;
`ifdef CODIX_RISC_CA_ISSUE_BYPASS_EN
      end else if (push_req) begin
         slot_op = SLOT_LOAD_BYPASS;
`endif
      end else begin
         slot_op = SLOT_IDLE;
      end
   end

   // A word pushed while the head is popped lands behind it in the FIFO,
   // which is why the push is only withheld on the bypass path.
   assign fifo_pop  = (slot_op == SLOT_LOAD_FIFO);
   assign fifo_push = push_req && (slot_op != SLOT_LOAD_BYPASS);

   always_comb begin
      act_d   = 1'b0;
      instr_d = NOP_INSTR;
      case (slot_op)
         SLOT_HOLD: begin
            act_d   = act_q;
            instr_d = instr_q;
         end
         SLOT_LOAD_FIFO: begin
            act_d   = 1'b1;
            instr_d = fifo_head;
         end
         SLOT_LOAD_BYPASS: begin
            act_d   = 1'b1;
            instr_d = fetch_instr;
         end
         default: begin
            act_d   = 1'b0;
            instr_d = NOP_INSTR;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         act_q   <= 1'b0;
         instr_q <= NOP_INSTR;
      end else begin
         act_q   <= act_d;
         instr_q <= instr_d;
      end
   end

   assign ACT         = act_q;
   assign id_instr_Q0 = instr_q;

   codix_risc_ca_issue_fifo #(
      .W     (INSTR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .clr   (flush),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fetch_instr),
      .head  (fifo_head),
      .count (fifo_cnt),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_codix_risc_ca_id_instr_issue.sv
// -----------------------------------------------------------------------------
// tb_codix_risc_ca_id_instr_issue
//
// Bench for the decoder issue stage. A queue-based reference model tracks
// the buffered words and the presented slot; every cycle is compared against
// it, and directed vectors plus hand-written sequences pin down latency,
// stall, flush, reset and wrap-around behaviour.
// -----------------------------------------------------------------------------
module tb_codix_risc_ca_id_instr_issue;

   localparam int         W     = 12;
   localparam int         DEPTH = 4;
   localparam logic [W-1:0] NOP = 12'h000;
`ifdef CODIX_RISC_CA_ISSUE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          fetch_valid = 1'b0;
   logic [W-1:0]  fetch_instr = '0;
   logic          fetch_ready;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic          ACT;
   logic [W-1:0]  id_instr_Q0;
   logic [2:0]    fifo_cnt;

   always #5 CLK = ~CLK;

   codix_risc_ca_id_instr_issue dut (
      .CLK         (CLK),
      .RST         (RST),
      .fetch_valid (fetch_valid),
      .fetch_instr (fetch_instr),
      .fetch_ready (fetch_ready),
      .stall       (stall),
      .flush       (flush),
      .ACT         (ACT),
      .id_instr_Q0 (id_instr_Q0),
      .fifo_cnt    (fifo_cnt)
   );

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   // ---------------- scoreboard / reference model ----------------
   logic [W-1:0] exp_q[$];     // words accepted but not yet presented
   logic         m_act = 1'b0;
   logic [W-1:0] m_instr = NOP;
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // One clock of the specified behaviour, using the inputs that were
   // present at the edge and the occupancy before it.
   task automatic model_step(input logic v, input logic [W-1:0] w, input logic s,
                             input logic f, input logic r);
      bit push;
      if (r || f) begin
         exp_q.delete();
         m_act   = 1'b0;
         m_instr = NOP;
      end else begin
         push = v && (exp_q.size() < DEPTH);
         if (s && m_act) begin
            if (push) exp_q.push_back(w);
         end else if (exp_q.size() != 0) begin
            m_instr = exp_q.pop_front();
            m_act   = 1'b1;
            if (push) exp_q.push_back(w);
         end else if (BYPASS && push) begin
            m_act   = 1'b1;
            m_instr = w;
         end else begin
            m_act   = 1'b0;
            m_instr = NOP;
            if (push) exp_q.push_back(w);
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic cycle(input logic v, input logic [W-1:0] w, input logic s,
                        input logic f, input logic r);
      fetch_valid = v;
      fetch_instr = w;
      stall       = s;
      flush       = f;
      RST         = r;
      @(posedge CLK);
      model_step(v, w, s, f, r);
      #1;
      chk("model_act",   ACT,         m_act);
      chk("model_instr", id_instr_Q0, m_instr);
      chk("model_cnt",   fifo_cnt,    exp_q.size());
      chk("model_ready", fetch_ready, exp_q.size() < DEPTH);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic         v;
      logic [W-1:0] w;
      logic         s;
      logic         f;
      logic         e_act;
      logic [W-1:0] e_instr;
      int           e_cnt;
   } vec_t;

   vec_t tbl[14];

   function automatic vec_t mk(input logic v, input logic [W-1:0] w, input logic s,
                               input logic e_act, input logic [W-1:0] e_instr, input int e_cnt);
      vec_t t;
      t.v = v; t.w = w; t.s = s; t.f = 1'b0;
      t.e_act = e_act; t.e_instr = e_instr; t.e_cnt = e_cnt;
      return t;
   endfunction

   logic [W-1:0] sent[10];
   logic [W-1:0] got_w[10];
   int           idx;
   int           got;
   logic         act_prev;
   logic         rdy_m;
   logic [W-1:0] wv;
   logic         vv;
   logic         sv;

   initial begin
`ifdef CODIX_RISC_CA_ISSUE_BYPASS_EN
      tbl[0]  = mk(1, 12'h0A1, 0, 1, 12'h0A1, 0);
      tbl[1]  = mk(1, 12'h0A2, 0, 1, 12'h0A2, 0);
      tbl[2]  = mk(0, 12'h000, 0, 0, 12'h000, 0);
      tbl[3]  = mk(0, 12'h000, 0, 0, 12'h000, 0);
      tbl[4]  = mk(1, 12'h155, 0, 1, 12'h155, 0);
`else
      tbl[0]  = mk(1, 12'h0A1, 0, 0, 12'h000, 1);
      tbl[1]  = mk(1, 12'h0A2, 0, 1, 12'h0A1, 1);
      tbl[2]  = mk(0, 12'h000, 0, 1, 12'h0A2, 0);
      tbl[3]  = mk(0, 12'h000, 0, 0, 12'h000, 0);
      tbl[4]  = mk(1, 12'h155, 0, 0, 12'h000, 1);
`endif
      // Stall row 5 meets an empty slot (default build) or a full one
      // (bypass build); both end up holding 12'h155 below.
      tbl[5]  = mk(1, 12'h201, 1, 1, 12'h155, 1);
      tbl[6]  = mk(1, 12'h202, 1, 1, 12'h155, 2);
      tbl[7]  = mk(1, 12'h203, 1, 1, 12'h155, 3);
      tbl[8]  = mk(1, 12'h204, 1, 1, 12'h155, 4);
      tbl[9]  = mk(1, 12'h205, 0, 1, 12'h201, 3);  // full: 12'h205 refused
      tbl[10] = mk(0, 12'h000, 0, 1, 12'h202, 2);
      tbl[11] = mk(0, 12'h000, 0, 1, 12'h203, 1);
      tbl[12] = mk(0, 12'h000, 0, 1, 12'h204, 0);
      tbl[13] = mk(0, 12'h000, 0, 0, 12'h000, 0);

      // ---- reset ----
      cycle(0, '0, 0, 0, 1);
      cycle(0, '0, 0, 0, 1);
      chk("rst_act",   ACT,         0);
      chk("rst_instr", id_instr_Q0, 12'h000);
      chk("rst_cnt",   fifo_cnt,    0);
      chk("rst_ready", fetch_ready, 1);

      // ---- table vectors ----
      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].v, tbl[i].w, tbl[i].s, tbl[i].f, 0);
         chk($sformatf("vec%0d_act", i),   ACT,         tbl[i].e_act);
         chk($sformatf("vec%0d_instr", i), id_instr_Q0, tbl[i].e_instr);
         chk($sformatf("vec%0d_cnt", i),   fifo_cnt,    tbl[i].e_cnt);
         chk($sformatf("vec%0d_ready", i), fetch_ready, tbl[i].e_cnt < DEPTH);
      end

      // ---- flush with three buffered words, ACT high and a push of FFF ----
      cycle(1, 12'hA01, 0, 0, 0);
      for (int k = 0; k < 8 && exp_q.size() < 3; k++) cycle(1, 12'hA02 + W'(k), 1, 0, 0);
      chk("pre_flush_cnt", fifo_cnt, 3);
      chk("pre_flush_act", ACT, 1);
      cycle(1, 12'hFFF, 0, 1, 0);
      chk("flush_act",   ACT,         0);
      chk("flush_cnt",   fifo_cnt,    0);
      chk("flush_instr", id_instr_Q0, 12'h000);
      for (int k = 0; k < 4; k++) begin
         cycle(0, '0, 0, 0, 0);
         chk("flush_no_fff", (ACT && id_instr_Q0 == 12'hFFF), 0);
      end

      // ---- reset mid-stream with two buffered words ----
      cycle(1, 12'hB01, 0, 0, 0);
      for (int k = 0; k < 8 && exp_q.size() < 2; k++) cycle(1, 12'hB02 + W'(k), 1, 0, 0);
      chk("pre_rst_cnt", fifo_cnt, 2);
      cycle(1, 12'hBEE, 0, 1, 1);   // RST wins over flush and push
      chk("rst2_act",   ACT,         0);
      chk("rst2_instr", id_instr_Q0, 12'h000);
      chk("rst2_cnt",   fifo_cnt,    0);
      chk("rst2_ready", fetch_ready, 1);
      cycle(1, 12'h321, 0, 0, 0);
      for (int k = 0; k < 5 && !ACT; k++) cycle(0, '0, 0, 0, 0);
      chk("post_rst_act",   ACT,         1);
      chk("post_rst_first", id_instr_Q0, 12'h321);

      // ---- stall while the slot is empty does not block loading ----
      cycle(0, '0, 0, 0, 0);
      cycle(0, '0, 0, 0, 0);
      chk("idle_pre_act", ACT, 0);
      cycle(1, 12'h042, 1, 0, 0);
      cycle(0, '0, 1, 0, 0);
      chk("idle_stall_act",   ACT,         1);
      chk("idle_stall_instr", id_instr_Q0, 12'h042);
      cycle(0, '0, 0, 0, 0);
      cycle(0, '0, 0, 0, 0);

      // ---- 10 words through a full FIFO, wrapping the pointers ----
      for (int i = 0; i < 10; i++) sent[i] = 12'h300 + W'(i);
      idx = 0;
      got = 0;
      act_prev = ACT;
      for (int c = 0; c < 80 && got < 10; c++) begin
         vv    = (idx < 10);
         wv    = vv ? sent[idx] : '0;
         sv    = (c >= 1 && c < 7);
         rdy_m = (exp_q.size() < DEPTH);
         cycle(vv, wv, sv, 0, 0);
         if (vv && rdy_m) idx++;
         if (ACT && !(sv && act_prev)) begin
            got_w[got] = id_instr_Q0;
            got++;
         end
         act_prev = ACT;
      end
      chk("wrap_count", got, 10);
      for (int i = 0; i < got; i++) chk($sformatf("wrap_word%0d", i), got_w[i], sent[i]);
      cycle(0, '0, 0, 0, 0);
      cycle(0, '0, 0, 0, 0);

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 99) < 70,
               W'($urandom_range(0, 4095)),
               $urandom_range(0, 99) < 30,
               $urandom_range(0, 99) < 4,
               $urandom_range(0, 199) < 2);
      end

      // ---- report ----
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
